register_file_sb: RTL

Parametrised register file for the pipelined MIPS core. It provides two combinational read ports and two write ports: primary for writeback, secondary for late load/multi-cycle results. An optional write-to-read bypass is included. An integrated per-register scoreboard tracks in-flight destinations and generates the issue stall for RAW and WAW hazards. Register 0 is hardwired to zero, never written and never pending.

---
 rtl/register_file_sb.sv | 110 +++++++++++
 1 files changed

// File: rtl/register_file_sb.sv
// Register file with two read ports, primary/secondary write ports, optional
// write-to-read bypass and a per-register scoreboard that raises the issue stall.
module register_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    input  logic                  rd_use_a,
    input  logic                  rd_use_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  rd_pend_a,
    output logic                  rd_pend_b,
    input  logic                  we_p,
    input  logic [ADDR_WIDTH-1:0] wa_p,
    input  logic [DATA_WIDTH-1:0] wd_p,
    input  logic                  we_s,
    input  logic [ADDR_WIDTH-1:0] wa_s,
    input  logic [DATA_WIDTH-1:0] wd_s,
    input  logic                  issue_valid,
    input  logic                  issue_wen,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
    output logic                  stall,
    output logic [ADDR_WIDTH:0]   busy_count
);

    // Storage spans the full address space so every index is exactly in range;
    // entries at or above DEPTH are never written and stay zero.
    localparam int NREG = 2 ** ADDR_WIDTH;
    localparam bit BYP  = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] regs [NREG];
    logic [NREG-1:0]       pending;
    logic [NREG-1:0]       pending_nx;
    logic [NREG-1:0]       clr;
    logic [NREG-1:0]       set_v;
    logic [ADDR_WIDTH:0]   count_nx;
    logic                  vp;
    logic                  vs;
    logic                  waw;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a != '0) && (int'(a) < DEPTH);
    endfunction

    assign vp = we_p && in_range(wa_p);
    assign vs = we_s && in_range(wa_s);

    always_comb begin
        clr = '0;
        for (int r = 1; r < NREG; r++) begin
            clr[r] = (vp && (int'(wa_p) == r)) || (vs && (int'(wa_s) == r));
        end
    end

    // Primary write takes precedence over secondary when both hit the read address.
    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        if (in_range(rd_addr_a)) begin
            if (BYP && vp && (wa_p == rd_addr_a))      rd_data_a = wd_p;
            else if (BYP && vs && (wa_s == rd_addr_a)) rd_data_a = wd_s;
            else                                       rd_data_a = regs[rd_addr_a];
        end
        if (in_range(rd_addr_b)) begin
            if (BYP && vp && (wa_p == rd_addr_b))      rd_data_b = wd_p;
            else if (BYP && vs && (wa_s == rd_addr_b)) rd_data_b = wd_s;
            else                                       rd_data_b = regs[rd_addr_b];
        end
    end

    assign rd_pend_a = in_range(rd_addr_a) && pending[rd_addr_a] && !(BYP && clr[rd_addr_a]);
    assign rd_pend_b = in_range(rd_addr_b) && pending[rd_addr_b] && !(BYP && clr[rd_addr_b]);
    assign waw       = issue_wen && pending[issue_addr] && !clr[issue_addr];
    assign stall     = issue_valid && ((rd_use_a && rd_pend_a) || (rd_use_b && rd_pend_b) || waw);

    // A new producer supersedes a completing one, so set wins over clear.
    always_comb begin
        set_v      = '0;
        pending_nx = '0;
        count_nx   = '0;
        for (int r = 1; r < NREG; r++) begin
            set_v[r]      = issue_valid && issue_wen && !stall && in_range(issue_addr)
                            && (int'(issue_addr) == r);
            pending_nx[r] = set_v[r] || (pending[r] && !clr[r]);
            count_nx      = count_nx + (ADDR_WIDTH+1)'(pending_nx[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
            pending    <= '0;
            busy_count <= '0;
        end else begin
            if (vs) regs[wa_s] <= wd_s;
            if (vp) regs[wa_p] <= wd_p;
            pending    <= pending_nx;
            busy_count <= count_nx;
        end
    end

endmodule
